// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
package fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 64;
    localparam int DEF_MARGIN = 4;

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_mem_1r1w.sv
// Storage array: synchronous write, asynchronous read, contents never reset.
module fifo_mem_1r1w
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with registered or first-word-fall-through read,
// full-range occupancy count, threshold flags and sticky error flags.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - DEF_MARGIN,
    parameter int AE_LEVEL = DEF_MARGIN,
    parameter int FWFT     = 0,
    localparam int ADDR_W  = clog2(DEPTH),
    localparam int CNT_W   = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] buf_in,
    input  logic              rd_en,
    input  logic              clr_err,
    output logic [DATA_W-1:0] buf_out,
    output logic              buf_empty,
    output logic              buf_full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [CNT_W-1:0]  fifo_counter,
    output logic              overflow,
    output logic              underflow
);

    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              overflow_reg;
    logic              underflow_reg;
    logic [DATA_W-1:0] rd_data;
    logic              wr_acc;
    logic              rd_acc;

    // Acceptance uses the flags decoded from the pre-edge count, so a write
    // while full is refused even if a read frees a slot in the same cycle.
    assign wr_acc = wr_en && !buf_full;
    assign rd_acc = rd_en && !buf_empty;

    fifo_mem_1r1w #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_reg),
        .wr_data (buf_in),
        .rd_addr (rd_ptr_reg),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            // Set has priority over clear.
            if (wr_en && buf_full) begin
                overflow_reg <= 1'b1;
            end else if (clr_err) begin
                overflow_reg <= 1'b0;
            end
            if (rd_en && buf_empty) begin
                underflow_reg <= 1'b1;
            end else if (clr_err) begin
                underflow_reg <= 1'b0;
            end
        end
    end

    assign fifo_counter = count_reg;
    assign buf_empty    = (count_reg == '0);
    assign buf_full     = (count_reg == CNT_W'(DEPTH));
    assign almost_empty = (count_reg <= CNT_W'(AE_LEVEL));
    assign almost_full  = (count_reg >= CNT_W'(AF_LEVEL));
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    generate
        if (FWFT != 0) begin : g_fwft
            assign buf_out = rd_data;
        end else begin : g_registered
            logic [DATA_W-1:0] buf_out_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    buf_out_reg <= '0;
                end else if (rd_acc) begin
                    buf_out_reg <= rd_data;
                end
            end

            assign buf_out = buf_out_reg;
        end
    endgenerate

endmodule
